// File: rtl/rand_arbiter_pkg.sv
// Shared types and constants for the random-number arbiter.
// The RAND_ARBITER_FREERUN_EN build option is read in rand_arbiter.sv.
package rand_pkg;
  localparam int RAND_W = 16;
  localparam int SH_A   = 3;
  localparam int SH_B   = 11;
  localparam int SH_C   = 7;

  localparam logic [RAND_W-1:0] SEED_FIX = 16'h0001;

  typedef enum logic {WARM, READY} state_e;

  // An all-zero state is a fixed point of xorshift, so it is never loaded.
  function automatic logic [RAND_W-1:0] fix_seed(input logic [RAND_W-1:0] s);
    return (s == '0) ? SEED_FIX : s;
  endfunction
endpackage

// File: rtl/rand_arbiter_if.sv
// Request/grant and seeding bundle between the arbiter and its requesters.
interface rand_arbiter_if #(parameter int N_REQ = 4);
  import rand_pkg::*;

  logic [RAND_W-1:0] seed;
  logic              seed_load;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [RAND_W-1:0] rand_out;
  logic              rand_valid;
  logic              ready;

  modport master (
    output seed, seed_load, req,
    input  gnt, rand_out, rand_valid, ready
  );

  modport slave (
    input  seed, seed_load, req,
    output gnt, rand_out, rand_valid, ready
  );
endinterface

// File: rtl/xorshift16_step.sv
// One combinational xorshift step: x^=x<<3; x^=x>>11; x^=x<<7 (16-bit).
module xorshift16_step
  import rand_pkg::*;
(
  input  logic [RAND_W-1:0] x_i,
  output logic [RAND_W-1:0] x_o
);
  logic [RAND_W-1:0] a, b;

  assign a   = x_i ^ (x_i << SH_A);
  assign b   = a ^ (a >> SH_B);
  assign x_o = b ^ (b << SH_C);
endmodule

// File: rtl/rand_arbiter.sv
// Round-robin sharing of one xorshift16 generator; one value consumed per grant.
// Define RAND_ARBITER_FREERUN_EN to step the generator on every READY cycle.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 2
) (
  input  logic           clk,
  input  logic           rst,
  rand_arbiter_if.slave  bus
);
  localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]  WARM_CNT = 4'(WARMUP);
  localparam state_e      INIT_ST  = (WARMUP > 0) ? WARM : READY;

  logic [RAND_W-1:0] x_q, x_d, x_step;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  state_e            state_q, state_d;

  logic [PTR_W-1:0]  idx [N_REQ];
  logic [N_REQ-1:0]  gnt_c;
  logic [PTR_W-1:0]  gidx;
  logic              found;
  logic              gnt_en;

  xorshift16_step u_step (
    .x_i (x_q),
    .x_o (x_step)
  );

  // Rotating priority: first asserted request at or after ptr, wrapping.
  always_comb begin
    gnt_c = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx[i] = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && bus.req[idx[i]]) begin
        found          = 1'b1;
        gidx           = idx[i];
        gnt_c[idx[i]]  = 1'b1;
      end
    end
  end

  assign gnt_en         = (state_q == READY) && !rst && !bus.seed_load;
  assign bus.gnt        = gnt_en ? gnt_c : '0;
  assign bus.rand_valid = gnt_en && found;
  assign bus.rand_out   = x_q;
  assign bus.ready      = (state_q == READY) && (!rst || (WARMUP == 0));

  always_comb begin
    x_d     = x_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (bus.seed_load) begin
      x_d     = fix_seed(bus.seed);
      cnt_d   = WARM_CNT;
      state_d = INIT_ST;
    end else begin
      case (state_q)
        WARM: begin
          x_d   = x_step;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = READY;
        end
        READY: begin
`ifdef RAND_ARBITER_FREERUN_EN
          x_d = x_step;
`endif
          if (found) begin
            x_d   = x_step;
            ptr_d = PTR_W'((int'(gidx) + 1) % N_REQ);
          end
        end
        default: state_d = INIT_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= fix_seed(bus.seed);
      ptr_q   <= '0;
      cnt_q   <= WARM_CNT;
      state_q <= INIT_ST;
    end else begin
      x_q     <= x_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: WARMUP=0 instance driven from a vector table with a
// scoreboard queue, WARMUP=2 instance exercised by hand-written sequences.
module tb_rand_arbiter;
  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

`ifdef RAND_ARBITER_FREERUN_EN
  localparam bit FR = 1'b1;
`else
  localparam bit FR = 1'b0;
`endif

  rand_arbiter_if #(.N_REQ(4)) ifa ();
  rand_arbiter_if #(.N_REQ(4)) ifb ();

  rand_arbiter #(.N_REQ(4), .WARMUP(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rand_arbiter #(.N_REQ(4), .WARMUP(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          sl;
    logic [15:0] seed;
    logic [3:0]  req;
    logic [3:0]  gnt;
  } vec_t;

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] rnd;
    bit          chk_rnd;
  } exp_t;

  vec_t vt[22];
  exp_t sbq[$];
  logic [15:0] mx;
  bit          mx_known;

  function automatic logic [15:0] stp(input logic [15:0] v);
    logic [15:0] t;
    t = v ^ (v << 3);
    t = t ^ (t >> 11);
    t = t ^ (t << 7);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one row on dut_a, push its expectation, compare at negedge, update model.
  task automatic apply(input vec_t v, input string nm);
    exp_t e, g;
    rst           = v.rst;
    ifa.seed_load = v.sl;
    ifa.seed      = v.seed;
    ifa.req       = v.req;
    e.gnt     = v.gnt;
    e.rnd     = mx;
    e.chk_rnd = mx_known;
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      g = sbq.pop_front();
      chk({nm, "_gnt"}, 32'(ifa.gnt), 32'(g.gnt));
      chk({nm, "_valid"}, 32'(ifa.rand_valid), 32'(g.gnt != 4'd0));
      chk({nm, "_ready"}, 32'(ifa.ready), 32'd1);
      if (g.chk_rnd) chk({nm, "_rand"}, 32'(ifa.rand_out), 32'(g.rnd));
    end
    if (v.rst || v.sl) mx = (v.seed == 16'd0) ? 16'h0001 : v.seed;
    else if (v.gnt != 4'd0 || FR) mx = stp(mx);
    mx_known = 1'b1;
    next_cyc();
  endtask

  initial begin
    bit saw_zero;
    //           rst  sl   seed      req      gnt
    vt[0]  = '{1'b1, 1'b0, 16'h0004, 4'b0000, 4'b0000};
    vt[1]  = '{1'b0, 1'b0, 16'h0004, 4'b0001, 4'b0001};
    vt[2]  = '{1'b0, 1'b0, 16'h0004, 4'b0000, 4'b0000};
    vt[3]  = '{1'b0, 1'b0, 16'h0004, 4'b0000, 4'b0000};
    vt[4]  = '{1'b0, 1'b0, 16'h0004, 4'b1111, 4'b0010};
    vt[5]  = '{1'b0, 1'b0, 16'h0004, 4'b1111, 4'b0100};
    vt[6]  = '{1'b0, 1'b0, 16'h0004, 4'b1111, 4'b1000};
    vt[7]  = '{1'b0, 1'b0, 16'h0004, 4'b1111, 4'b0001};
    vt[8]  = '{1'b0, 1'b0, 16'h0004, 4'b1111, 4'b0010};
    vt[9]  = '{1'b0, 1'b0, 16'h0004, 4'b1010, 4'b1000};
    vt[10] = '{1'b0, 1'b0, 16'h0004, 4'b1010, 4'b0010};
    vt[11] = '{1'b0, 1'b0, 16'h0004, 4'b1010, 4'b1000};
    vt[12] = '{1'b0, 1'b1, 16'h0004, 4'b1010, 4'b0000};
    vt[13] = '{1'b0, 1'b0, 16'h0004, 4'b1010, 4'b0010};
    vt[14] = '{1'b0, 1'b0, 16'h0004, 4'b0001, 4'b0001};
    vt[15] = '{1'b0, 1'b0, 16'h0004, 4'b0100, 4'b0100};
    vt[16] = '{1'b0, 1'b0, 16'h0004, 4'b0011, 4'b0001};
    vt[17] = '{1'b0, 1'b0, 16'h0004, 4'b0011, 4'b0010};
    vt[18] = '{1'b1, 1'b0, 16'h0000, 4'b1000, 4'b0000};
    vt[19] = '{1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0001};
    vt[20] = '{1'b0, 1'b1, 16'h0000, 4'b0100, 4'b0000};
    vt[21] = '{1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0100};

    mx = 16'h0; mx_known = 1'b0;
    rst = 1'b1;
    ifa.seed = 16'h0004; ifa.seed_load = 1'b0; ifa.req = 4'b0000;
    ifb.seed = 16'h0004; ifb.seed_load = 1'b0; ifb.req = 4'b0001;

    // WARMUP=2 instance: warm-up gating and first draw.
    next_cyc(); next_cyc();
    @(negedge clk);
    chk("b_rst_ready", 32'(ifb.ready), 0);
    chk("b_rst_gnt",   32'(ifb.gnt), 0);
    chk("b_rst_valid", 32'(ifb.rand_valid), 0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("b_w1_ready", 32'(ifb.ready), 0);
    chk("b_w1_gnt",   32'(ifb.gnt), 0);
    chk("b_w1_rand",  32'(ifb.rand_out), 32'h0004);
    next_cyc();
    @(negedge clk);
    chk("b_w2_ready", 32'(ifb.ready), 0);
    chk("b_w2_gnt",   32'(ifb.gnt), 0);
    chk("b_w2_rand",  32'(ifb.rand_out), 32'h1224);
    next_cyc();
    @(negedge clk);
    chk("b_r_ready", 32'(ifb.ready), 1);
    chk("b_r_gnt",   32'(ifb.gnt), 32'b0001);
    chk("b_r_rand",  32'(ifb.rand_out), 32'h0914);
    next_cyc();
    ifb.req = 4'b0000;
    @(negedge clk);
    chk("b_idle_valid", 32'(ifb.rand_valid), 0);
    chk("b_idle_rand",  32'(ifb.rand_out), 32'(stp(16'h0914)));

    // Reset again mid-warm-up: warm-up restarts from the seed.
    next_cyc();
    rst = 1'b1; next_cyc();
    rst = 1'b0; ifb.req = 4'b0010;
    @(negedge clk);
    chk("b_mw_ready0", 32'(ifb.ready), 0);
    next_cyc();
    rst = 1'b1; next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("b_mw_ready1", 32'(ifb.ready), 0);
    chk("b_mw_gnt1",   32'(ifb.gnt), 0);
    chk("b_mw_rand1",  32'(ifb.rand_out), 32'h0004);
    next_cyc();
    @(negedge clk);
    chk("b_mw_ready2", 32'(ifb.ready), 0);
    chk("b_mw_rand2",  32'(ifb.rand_out), 32'h1224);
    next_cyc();
    @(negedge clk);
    chk("b_mw_ready3", 32'(ifb.ready), 1);
    chk("b_mw_gnt3",   32'(ifb.gnt), 32'b0010);
    chk("b_mw_rand3",  32'(ifb.rand_out), 32'h0914);
    next_cyc();
    ifb.req = 4'b0000;

    // WARMUP=0 instance: vector table.
    for (int i = 0; i < 22; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Long run from seed 0: value must never reach zero.
    saw_zero = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      vec_t v;
      v = '{1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0001};
      if (ifa.rand_out == 16'h0000) saw_zero = 1'b1;
      apply(v, "long");
    end
    chk("long_nonzero", 32'(saw_zero), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
